// File: rtl/mips_pkg.sv
// Shared constants for the MIPS execute stage: ALUOp codes, funct values,
// control-bit positions inside the WB/MEM/EXE bundles and the mul/div FSM states.
package mips_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

    localparam int WB_REGWRITE  = 1;
    localparam int WB_MEMTOREG  = 0;
    localparam int MEM_BRANCH   = 2;
    localparam int MEM_MEMREAD  = 1;
    localparam int MEM_MEMWRITE = 0;
    localparam int EXE_REGDST   = 3;
    localparam int EXE_ALUOP_HI = 2;
    localparam int EXE_ALUOP_LO = 1;
    localparam int EXE_ALUSRC   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIN  = 2'd2
    } mdState_t;

    // mult/multu/div/divu occupy funct 0x18..0x1B
    function automatic logic isMulDivFunct(input logic [5:0] funct);
        return funct[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX bundle, forwarding sources and EX/MEM outputs of the execute stage.
// master = upstream pipeline side, slave = ex_stage.
interface ex_stage_if;
    import mips_pkg::*;

    logic [31:0] pc;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] sign_extended;
    logic [4:0]  rs;
    logic [4:0]  instruction1;
    logic [4:0]  instruction2;
    logic [1:0]  WB;
    logic [2:0]  MEM;
    logic [3:0]  EXE;

    logic        exmem_regwrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_value;
    logic        memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_value;

    logic        stall;
    logic [31:0] aluResultOut;
    logic [31:0] writeDataOut;
    logic [31:0] branchTargetOut;
    logic        zeroOut;
    logic [4:0]  writeRegOut;
    logic [1:0]  WBOut;
    logic [2:0]  MEMOut;

    modport master (
        output pc, readData1, readData2, sign_extended, rs, instruction1, instruction2,
        output WB, MEM, EXE,
        output exmem_regwrite, exmem_rd, exmem_value, memwb_regwrite, memwb_rd, memwb_value,
        input  stall, aluResultOut, writeDataOut, branchTargetOut, zeroOut,
        input  writeRegOut, WBOut, MEMOut
    );

    modport slave (
        input  pc, readData1, readData2, sign_extended, rs, instruction1, instruction2,
        input  WB, MEM, EXE,
        input  exmem_regwrite, exmem_rd, exmem_value, memwb_regwrite, memwb_rd, memwb_value,
        output stall, aluResultOut, writeDataOut, branchTargetOut, zeroOut,
        output writeRegOut, WBOut, MEMOut
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider owning HI and LO.
// Only compiled when MIPS_MULDIV_EN is defined; otherwise no HI/LO storage exists.
`ifdef MIPS_MULDIV_EN
module muldiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic        i_isDiv,
    input  logic [31:0] i_opA,
    input  logic [31:0] i_opB,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);
    import mips_pkg::*;

    mdState_t    r_state;
    mdState_t    w_nextState;
    logic [4:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opB;
    logic [31:0] r_dividend;
    logic        r_isDiv;
    logic        r_negRes;
    logic        r_negRem;
    logic        r_divZero;
    logic [31:0] r_hiReg;
    logic [31:0] r_loReg;

    logic        w_signA;
    logic        w_signB;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic [32:0] w_mulSum;
    logic [32:0] w_divRem;
    logic [32:0] w_divDiff;
    logic [63:0] w_prod;
    logic [63:0] w_prodFix;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // Work on magnitudes; the sign is re-applied in FIN
    assign w_signA   = i_signed & i_opA[31];
    assign w_signB   = i_signed & i_opB[31];
    assign w_magA    = w_signA ? (32'd0 - i_opA) : i_opA;
    assign w_magB    = w_signB ? (32'd0 - i_opB) : i_opB;

    assign w_mulSum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opB} : 33'd0);
    assign w_divRem  = {r_hi, r_lo[31]};
    assign w_divDiff = w_divRem - {1'b0, r_opB};

    assign w_prod    = {r_hi, r_lo};
    assign w_prodFix = r_negRes ? (64'd0 - w_prod) : w_prod;
    assign w_quo     = r_negRes ? (32'd0 - r_lo) : r_lo;
    assign w_rem     = r_negRem ? (32'd0 - r_hi) : r_hi;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (i_start) w_nextState = BUSY;
            BUSY:    if (r_count == 5'd0) w_nextState = FIN;
            FIN:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // HI holds the partial product / running remainder, LO the multiplier / quotient
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count    <= 5'd0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opB      <= '0;
            r_dividend <= '0;
            r_isDiv    <= 1'b0;
            r_negRes   <= 1'b0;
            r_negRem   <= 1'b0;
            r_divZero  <= 1'b0;
            r_hiReg    <= '0;
            r_loReg    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_count    <= 5'd31;
                        r_hi       <= '0;
                        r_lo       <= w_magA;
                        r_opB      <= w_magB;
                        r_dividend <= i_opA;
                        r_isDiv    <= i_isDiv;
                        r_negRes   <= w_signA ^ w_signB;
                        r_negRem   <= w_signA;
                        r_divZero  <= (i_opB == 32'd0);
                    end
                end
                BUSY: begin
                    r_count <= r_count - 5'd1;
                    if (r_isDiv) begin
                        if (!w_divDiff[32]) begin
                            r_hi <= w_divDiff[31:0];
                            r_lo <= {r_lo[30:0], 1'b1};
                        end else begin
                            r_hi <= w_divRem[31:0];
                            r_lo <= {r_lo[30:0], 1'b0};
                        end
                    end else begin
                        r_hi <= w_mulSum[32:1];
                        r_lo <= {w_mulSum[0], r_lo[31:1]};
                    end
                end
                FIN: begin
                    if (r_isDiv && r_divZero) begin
                        r_hiReg <= r_dividend;
                        r_loReg <= 32'hFFFF_FFFF;
                    end else if (r_isDiv) begin
                        r_hiReg <= w_rem;
                        r_loReg <= w_quo;
                    end else begin
                        r_hiReg <= w_prodFix[63:32];
                        r_loReg <= w_prodFix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_hi   = r_hiReg;
    assign o_lo   = r_loReg;

endmodule
`endif

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, branch target and the EX/MEM register.
// Define MIPS_MULDIV_EN to include the iterative mul/div unit with HI/LO and stall.
module ex_stage (
    input logic       clock,
    input logic       reset,
    ex_stage_if.slave bus
);
    import mips_pkg::*;

    logic [31:0] w_opA;
    logic [31:0] w_opB;
    logic [31:0] w_aluB;
    logic [1:0]  w_aluOp;
    logic [5:0]  w_funct;
    logic [31:0] w_result;
    logic        w_isMulDiv;
    logic        w_bubble;
    logic        w_stall;
    logic [31:0] w_hi;
    logic [31:0] w_lo;

    logic [31:0] r_aluResult;
    logic [31:0] r_writeData;
    logic [31:0] r_branchTarget;
    logic        r_zero;
    logic [4:0]  r_writeReg;
    logic [1:0]  r_wb;
    logic [2:0]  r_mem;

    // EX/MEM beats MEM/WB because it carries the younger result
    function automatic logic [31:0] forwardOperand(
        input logic [4:0]  src,
        input logic [31:0] regVal,
        input logic        exRegWrite,
        input logic [4:0]  exRd,
        input logic [31:0] exVal,
        input logic        wbRegWrite,
        input logic [4:0]  wbRd,
        input logic [31:0] wbVal
    );
        if (exRegWrite && exRd != 5'd0 && exRd == src) return exVal;
        if (wbRegWrite && wbRd != 5'd0 && wbRd == src) return wbVal;
        return regVal;
    endfunction

    assign w_opA = forwardOperand(bus.rs, bus.readData1,
                                  bus.exmem_regwrite, bus.exmem_rd, bus.exmem_value,
                                  bus.memwb_regwrite, bus.memwb_rd, bus.memwb_value);
    assign w_opB = forwardOperand(bus.instruction1, bus.readData2,
                                  bus.exmem_regwrite, bus.exmem_rd, bus.exmem_value,
                                  bus.memwb_regwrite, bus.memwb_rd, bus.memwb_value);

    assign w_aluOp    = bus.EXE[EXE_ALUOP_HI:EXE_ALUOP_LO];
    assign w_funct    = bus.sign_extended[5:0];
    assign w_aluB     = bus.EXE[EXE_ALUSRC] ? bus.sign_extended : w_opB;
    assign w_isMulDiv = (w_aluOp == ALUOP_FUNCT) && isMulDivFunct(w_funct);
    assign w_bubble   = w_stall || w_isMulDiv;

`ifdef MIPS_MULDIV_EN
    logic w_start;

    assign w_start = w_isMulDiv && !w_stall;

    muldiv_unit u_muldiv (
        .clock   (clock),
        .reset   (reset),
        .i_start (w_start),
        .i_signed(!w_funct[0]),
        .i_isDiv (w_funct[1]),
        .i_opA   (w_opA),
        .i_opB   (w_opB),
        .o_busy  (w_stall),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );
`else
    assign w_stall = 1'b0;
    assign w_hi    = '0;
    assign w_lo    = '0;
`endif

    always_comb begin
        w_result = '0;
        case (w_aluOp)
            ALUOP_ADD: w_result = w_opA + w_aluB;
            ALUOP_SUB: w_result = w_opA - w_aluB;
            ALUOP_OR:  w_result = w_opA | w_aluB;
            default: begin
                case (w_funct)
                    FUNCT_ADD, FUNCT_ADDU: w_result = w_opA + w_aluB;
                    FUNCT_SUB, FUNCT_SUBU: w_result = w_opA - w_aluB;
                    FUNCT_AND:  w_result = w_opA & w_aluB;
                    FUNCT_OR:   w_result = w_opA | w_aluB;
                    FUNCT_XOR:  w_result = w_opA ^ w_aluB;
                    FUNCT_NOR:  w_result = ~(w_opA | w_aluB);
                    FUNCT_SLT:  w_result = {31'd0, $signed(w_opA) < $signed(w_aluB)};
                    FUNCT_SLTU: w_result = {31'd0, w_opA < w_aluB};
                    FUNCT_MFHI: w_result = w_hi;
                    FUNCT_MFLO: w_result = w_lo;
                    default:    w_result = '0;
                endcase
            end
        endcase
    end

    // Stalled cycles and the mul/div issue itself leave an all-zero bubble
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_aluResult    <= '0;
            r_writeData    <= '0;
            r_branchTarget <= '0;
            r_zero         <= 1'b0;
            r_writeReg     <= '0;
            r_wb           <= '0;
            r_mem          <= '0;
        end else if (w_bubble) begin
            r_aluResult    <= '0;
            r_writeData    <= '0;
            r_branchTarget <= '0;
            r_zero         <= 1'b0;
            r_writeReg     <= '0;
            r_wb           <= '0;
            r_mem          <= '0;
        end else begin
            r_aluResult    <= w_result;
            r_writeData    <= w_opB;
            r_branchTarget <= bus.pc + {bus.sign_extended[29:0], 2'b00};
            r_zero         <= (w_result == 32'd0);
            r_writeReg     <= bus.EXE[EXE_REGDST] ? bus.instruction2 : bus.instruction1;
            r_wb           <= bus.WB;
            r_mem          <= bus.MEM;
        end
    end

    assign bus.stall           = w_stall;
    assign bus.aluResultOut    = r_aluResult;
    assign bus.writeDataOut    = r_writeData;
    assign bus.branchTargetOut = r_branchTarget;
    assign bus.zeroOut         = r_zero;
    assign bus.writeRegOut     = r_writeReg;
    assign bus.WBOut           = r_wb;
    assign bus.MEMOut          = r_mem;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; expectations for the mul/div path
// follow whether MIPS_MULDIV_EN is defined for the build.
module tb_ex_stage;
    import mips_pkg::*;

`ifdef MIPS_MULDIV_EN
    localparam int          EXP_STALL   = 33;
    localparam logic        EXP_BUSY    = 1'b1;
    localparam logic [31:0] EXP_MULT_LO = 32'hFFFF_FFF1;
    localparam logic [31:0] EXP_MULT_HI = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_DIV_LO  = 32'hFFFF_FFFD;
    localparam logic [31:0] EXP_DIV_HI  = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_DIVU_LO = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_DIVU_HI = 32'd9;
`else
    localparam int          EXP_STALL   = 0;
    localparam logic        EXP_BUSY    = 1'b0;
    localparam logic [31:0] EXP_MULT_LO = 32'd0;
    localparam logic [31:0] EXP_MULT_HI = 32'd0;
    localparam logic [31:0] EXP_DIV_LO  = 32'd0;
    localparam logic [31:0] EXP_DIV_HI  = 32'd0;
    localparam logic [31:0] EXP_DIVU_LO = 32'd0;
    localparam logic [31:0] EXP_DIVU_HI = 32'd0;
`endif

    logic clock = 1'b0;
    logic reset;
    int   testCount = 0;
    int   failCount = 0;
    int   stallCycles;

    always #5 clock = ~clock;

    ex_stage_if bus ();

    ex_stage dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One ID/EX bundle with forwarding disabled; rs=1, rt=2, rd=3, RegDst=1
    task automatic applyStimulus(input logic [1:0] aluOp, input logic aluSrc,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm);
        bus.pc             = 32'd0;
        bus.readData1      = a;
        bus.readData2      = b;
        bus.sign_extended  = imm;
        bus.rs             = 5'd1;
        bus.instruction1   = 5'd2;
        bus.instruction2   = 5'd3;
        bus.WB             = 2'b10;
        bus.MEM            = 3'b000;
        bus.EXE            = {1'b1, aluOp, aluSrc};
        bus.exmem_regwrite = 1'b0;
        bus.exmem_rd       = 5'd0;
        bus.exmem_value    = 32'd0;
        bus.memwb_regwrite = 1'b0;
        bus.memwb_rd       = 5'd0;
        bus.memwb_value    = 32'd0;
    endtask

    task automatic aluStep(input string tag, input logic [1:0] aluOp, input logic aluSrc,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [31:0] exp);
        applyStimulus(aluOp, aluSrc, a, b, imm);
        tick();
        checkOutput(tag, bus.aluResultOut, exp);
    endtask

    // Issue a mul/div, hold the follow-up funct in ID/EX and count stall cycles
    task automatic issueMulDiv(input logic [5:0] funct, input logic [31:0] a,
                               input logic [31:0] b, input logic [5:0] nextFunct,
                               output int cycles);
        applyStimulus(ALUOP_FUNCT, 1'b0, a, b, {26'd0, funct});
        tick();
        checkOutput("mdIssueBubbleWB", 32'(bus.WBOut), 32'd0);
        applyStimulus(ALUOP_FUNCT, 1'b0, 32'd0, 32'd0, {26'd0, nextFunct});
        cycles = 0;
        while (bus.stall === 1'b1 && cycles < 60) begin
            if (cycles == 5) checkOutput("stallBubbleWB", 32'(bus.WBOut), 32'd0);
            cycles++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(ALUOP_ADD, 1'b0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("resetAlu", bus.aluResultOut, 32'd0);
        checkOutput("resetStall", 32'(bus.stall), 32'd0);
        checkOutput("resetWB", 32'(bus.WBOut), 32'd0);
        checkOutput("resetBranch", bus.branchTargetOut, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Forwarding: EX/MEM wins over MEM/WB, rd=0 never forwards
        applyStimulus(ALUOP_FUNCT, 1'b0, 32'd1, 32'd2, 32'h20);
        bus.rs             = 5'd5;
        bus.instruction1   = 5'd5;
        bus.instruction2   = 5'd8;
        bus.exmem_regwrite = 1'b1;
        bus.exmem_rd       = 5'd5;
        bus.exmem_value    = 32'd10;
        bus.memwb_regwrite = 1'b1;
        bus.memwb_rd       = 5'd5;
        bus.memwb_value    = 32'd99;
        tick();
        checkOutput("fwdExMem", bus.aluResultOut, 32'd20);
        checkOutput("fwdWriteData", bus.writeDataOut, 32'd10);
        checkOutput("fwdWriteReg", 32'(bus.writeRegOut), 32'd8);
        checkOutput("fwdWB", 32'(bus.WBOut), 32'd2);
        bus.exmem_rd = 5'd0;
        tick();
        checkOutput("fwdMemWb", bus.aluResultOut, 32'd198);
        checkOutput("fwdMemWbData", bus.writeDataOut, 32'd99);
        bus.memwb_regwrite = 1'b0;
        tick();
        checkOutput("fwdNone", bus.aluResultOut, 32'd3);

        // Branch compare and target with negative offset
        applyStimulus(ALUOP_SUB, 1'b0, 32'd7, 32'd7, 32'hFFFF_FFFE);
        bus.pc  = 32'h100;
        bus.MEM = 3'b100;
        bus.EXE[EXE_REGDST] = 1'b0;
        tick();
        checkOutput("branchAlu", bus.aluResultOut, 32'd0);
        checkOutput("branchZero", 32'(bus.zeroOut), 32'd1);
        checkOutput("branchTarget", bus.branchTargetOut, 32'h0000_00F8);
        checkOutput("branchMEM", 32'(bus.MEMOut), 32'd4);
        checkOutput("branchWriteRegRt", 32'(bus.writeRegOut), 32'd2);

        aluStep("subWrap", ALUOP_FUNCT, 1'b0, 32'd5, 32'd7, 32'h22, 32'hFFFF_FFFE);
        checkOutput("subWrapZero", 32'(bus.zeroOut), 32'd0);
        aluStep("and", ALUOP_FUNCT, 1'b0, 32'hF0F0, 32'hFF00, 32'h24, 32'h0000_F000);
        aluStep("or", ALUOP_FUNCT, 1'b0, 32'hF0F0, 32'hFF00, 32'h25, 32'h0000_FFF0);
        aluStep("xor", ALUOP_FUNCT, 1'b0, 32'hF0F0, 32'hFF00, 32'h26, 32'h0000_0FF0);
        aluStep("nor", ALUOP_FUNCT, 1'b0, 32'hF0F0, 32'hFF00, 32'h27, 32'hFFFF_000F);
        aluStep("sltSigned", ALUOP_FUNCT, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h2A, 32'd1);
        aluStep("sltuUnsigned", ALUOP_FUNCT, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h2B, 32'd0);
        aluStep("undefFunct", ALUOP_FUNCT, 1'b0, 32'd3, 32'd4, 32'h3F, 32'd0);
        checkOutput("undefZero", 32'(bus.zeroOut), 32'd1);
        aluStep("addImm", ALUOP_ADD, 1'b1, 32'd10, 32'd0, 32'hFFFF_FFFF, 32'd9);
        aluStep("orImm", ALUOP_OR, 1'b1, 32'hF0, 32'd0, 32'h0F, 32'hFF);

        // Signed multiply -3 * 5
        issueMulDiv(FUNCT_MULT, 32'hFFFF_FFFD, 32'd5, FUNCT_MFLO, stallCycles);
        checkOutput("multStallCycles", 32'(stallCycles), 32'(EXP_STALL));
        tick();
        checkOutput("multLo", bus.aluResultOut, EXP_MULT_LO);
        applyStimulus(ALUOP_FUNCT, 1'b0, 32'd0, 32'd0, {26'd0, FUNCT_MFHI});
        tick();
        checkOutput("multHi", bus.aluResultOut, EXP_MULT_HI);

        // Signed divide -7 / 2
        issueMulDiv(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, FUNCT_MFLO, stallCycles);
        tick();
        checkOutput("divLo", bus.aluResultOut, EXP_DIV_LO);
        applyStimulus(ALUOP_FUNCT, 1'b0, 32'd0, 32'd0, {26'd0, FUNCT_MFHI});
        tick();
        checkOutput("divHi", bus.aluResultOut, EXP_DIV_HI);

        // Unsigned divide by zero keeps the full latency
        issueMulDiv(FUNCT_DIVU, 32'd9, 32'd0, FUNCT_MFLO, stallCycles);
        checkOutput("divuZeroStallCycles", 32'(stallCycles), 32'(EXP_STALL));
        tick();
        checkOutput("divuZeroLo", bus.aluResultOut, EXP_DIVU_LO);
        applyStimulus(ALUOP_FUNCT, 1'b0, 32'd0, 32'd0, {26'd0, FUNCT_MFHI});
        tick();
        checkOutput("divuZeroHi", bus.aluResultOut, EXP_DIVU_HI);

        // Reset ten cycles into a multiply
        applyStimulus(ALUOP_FUNCT, 1'b0, 32'd7, 32'd9, {26'd0, FUNCT_MULTU});
        tick();
        applyStimulus(ALUOP_ADD, 1'b0, 32'd0, 32'd0, 32'd0);
        repeat (10) tick();
        checkOutput("stallBeforeReset", 32'(bus.stall), 32'(EXP_BUSY));
        reset = 1'b1;
        #2;
        checkOutput("midResetStall", 32'(bus.stall), 32'd0);
        checkOutput("midResetAlu", bus.aluResultOut, 32'd0);
        checkOutput("midResetWB", 32'(bus.WBOut), 32'd0);
        checkOutput("midResetWriteReg", 32'(bus.writeRegOut), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(ALUOP_FUNCT, 1'b0, 32'd0, 32'd0, {26'd0, FUNCT_MFHI});
        tick();
        checkOutput("hiAfterReset", bus.aluResultOut, 32'd0);
        checkOutput("stallAfterReset", 32'(bus.stall), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 32-bit MIPS pipeline: consumes the ID/EX register bundle, resolves operand forwarding, runs the ALU, and drives the EX/MEM register. It also owns an iterative multiply/divide unit with HI/LO registers. While that unit is busy it stalls the upstream stages and inserts bubbles downstream.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- clock  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pc, readData1, readData2, sign_extended  in  32 each  ID/EX bundle
- rs  in  5  source register rs, added to the bundle for forwarding
- instruction1  in  5  rt; instruction2  in  5  rd
- WB  in  2  [1]=RegWrite [0]=MemtoReg
- MEM  in  3  [2]=Branch [1]=MemRead [0]=MemWrite
- EXE  in  4  [3]=RegDst [2:1]=ALUOp [0]=ALUSrc
- exmem_regwrite, memwb_regwrite  in  1 each; exmem_rd, memwb_rd  in  5 each; exmem_value, memwb_value  in  32 each  forwarding sources
- stall  out  1  freeze PC, IF/ID and ID/EX
- aluResultOut, writeDataOut, branchTargetOut  out  32 each; zeroOut  out  1; writeRegOut  out  5; WBOut  out  2; MEMOut  out  3  EX/MEM register

## Operation
- Forwarding, per operand A (rs) and B (rt), highest priority first:
  - exmem_regwrite && exmem_rd!=0 && exmem_rd==src selects exmem_value.
  - memwb_regwrite && memwb_rd!=0 && memwb_rd==src selects memwb_value.
  - Otherwise the readData value.
- ALU B = ALUSrc ? sign_extended : forwarded B. writeDataOut = forwarded B.
- ALUOp encoding:
  - 00 = add.
  - 01 = sub.
  - 11 = or.
  - 10 = decode funct = sign_extended[5:0]:
    - 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt (signed), 0x2B sltu.
    - 0x10 mfhi, 0x12 mflo.
    - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu.
  - Undefined funct yields result 0.
- Add/sub wrap modulo 2^32; no overflow trap.
- zeroOut = (ALU result == 0).
- branchTargetOut = pc + (sign_extended << 2), truncated to 32 bits.
- writeRegOut = RegDst ? rd : rt.
- Mul/div FSM states: IDLE, BUSY, FIN.
  - IDLE: on a mul/div funct, capture forwarded A/B and the signed flag, set count=31, go to BUSY.
  - BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle; count decrements; at count 0 go to FIN.
  - FIN: apply sign correction, write HI/LO, go to IDLE.
- Results: mult writes {HI,LO} = 64-bit product; div writes LO = quotient, HI = remainder (remainder takes the dividend's sign).
- Divide by zero: LO=0xFFFFFFFF, HI=dividend; the same latency still applies.
- The mul/div instruction itself passes to EX/MEM as a bubble (WB=0, MEM=0).

## Timing
- EX/MEM outputs are registered: the bundle present in cycle N appears on the outputs after edge N.
- Reset values: every output 0, HI=LO=0, FSM IDLE, stall=0.
- stall is high from the cycle after mul/div issue through the FIN cycle, 33 cycles total.
- During stall, EX/MEM captures a bubble: WB, MEM and writeRegOut are 0; data fields are don't-care but driven 0.
- The instruction held in ID/EX re-evaluates in the first cycle with stall=0.
- A mfhi/mflo issued in that first cycle sees the new HI/LO, because they are written at the FIN edge.
- Back-to-back mul/div: the second issues when stall drops and overwrites HI/LO.
- Reset asserted mid-operation aborts immediately, drops stall, and clears HI/LO.

## Configuration
- MIPS_MULDIV_EN defined: the FSM, HI/LO and stall logic are compiled in as above.
- MIPS_MULDIV_EN undefined:
  - Funct 0x18-0x1B are treated as bubbles.
  - mfhi/mflo return 0.
  - stall is tied to 0.
  - No HI/LO storage exists.

## Structure
- mips_pkg holds:
  - ALUOp codes.
  - funct constants.
  - Control bit indices for WB, MEM and EXE.
  - The FSM state enum.
- Sub-module muldiv_unit: start, signed flag, mul/div select and operands in; busy, hi, lo out. ex_stage owns forwarding, the ALU and the EX/MEM register.

## Test plan
- Forwarding priority:
  - Stimulus: ALUOp=10, funct 0x20, rs=rt=5; exmem_rd=5 (value 10) and memwb_rd=5 (value 99), both regwrite.
  - Expected: aluResultOut=20 next cycle.
  - Then set exmem_rd=0; expected aluResultOut=198.
- Branch path:
  - Stimulus: ALUOp=01, A=B=7, pc=0x100, sign_extended=0xFFFFFFFE.
  - Expected: zeroOut=1, branchTargetOut=0xF8.
- Signed multiply:
  - Stimulus: mult with A=-3, B=5, then mflo and mfhi.
  - Expected: stall high exactly 33 cycles; LO=0xFFFFFFF1, HI=0xFFFFFFFF.
- Divide cases:
  - Stimulus: div -7/2; expected LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - Stimulus: divu 9/0; expected LO=0xFFFFFFFF, HI=9, same 33-cycle stall.
- Reset mid-multiply:
  - Stimulus: assert reset 10 cycles into BUSY.
  - Expected: stall=0 and all outputs 0 immediately; a subsequent mfhi returns 0.
- MIPS_MULDIV_EN undefined build:
  - Stimulus: mult.
  - Expected: stall never rises; mflo returns 0.
